instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the 128-word instruction memory.
- Holds the program counter (PC) and drives the memory's byte address each cycle.
- Memory read is combinational: the word returns in the same cycle.
- Registers the returned word into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump/jr redirects, stalls and flushes. No branch delay slot.

---
 rtl/instruction_fetch_unit_if.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 83 ++++++++
 tb/tb_instruction_fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: redirect/hazard controls,
// instruction memory port and the IF/ID pipeline register outputs.
// FETCH_PERF_EN adds the FetchCount/BubbleCount performance counters.
interface instruction_fetch_unit_if;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] PCOut;
  logic [31:0] InstructionID;
  logic [31:0] PCPlus4ID;
  logic        ValidID;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;

  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
           Jump, JumpTarget, IMemInstruction,
    input  IMemAddress, PCOut, InstructionID, PCPlus4ID, ValidID,
           FetchCount, BubbleCount
  );

  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
           Jump, JumpTarget, IMemInstruction,
    output IMemAddress, PCOut, InstructionID, PCPlus4ID, ValidID,
           FetchCount, BubbleCount
  );
`else
  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
           Jump, JumpTarget, IMemInstruction,
    input  IMemAddress, PCOut, InstructionID, PCPlus4ID, ValidID
  );

  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
           Jump, JumpTarget, IMemInstruction,
    output IMemAddress, PCOut, InstructionID, PCPlus4ID, ValidID
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: holds the PC, drives the combinational instruction
// memory address and registers the returned word into IF/ID.
// Redirect priority: BranchTaken > JumpReg > Jump > Stall > PC+4.
// Optional macro FETCH_PERF_EN adds fetch/bubble performance counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic                    Clk,
  input logic                    Reset,
  instruction_fetch_unit_if.slave bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        bubble;
  logic        load;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = bus.BranchTaken | bus.JumpReg | bus.Jump;
  assign bubble   = bus.Flush | redirect;
  assign load     = ~bubble & ~bus.Stall;

  // Next PC selection; loaded targets are forced word-aligned.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.BranchTaken)  next_pc = {bus.BranchTarget[31:2], 2'b00};
    else if (bus.JumpReg) next_pc = {bus.JumpRegTarget[31:2], 2'b00};
    else if (bus.Jump)    next_pc = {bus.JumpTarget[31:2], 2'b00};
    else if (bus.Stall)   next_pc = pc;
  end

  // PC register.
  always_ff @(posedge Clk) begin
    if (Reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  // IF/ID pipeline register: bubble on flush/redirect, hold on stall.
  always_ff @(posedge Clk) begin
    if (Reset || bubble) begin
      instr_id    <= NOP_WORD;
      pc_plus4_id <= '0;
      valid_id    <= 1'b0;
    end else if (load) begin
      instr_id    <= bus.IMemInstruction;
      pc_plus4_id <= pc_plus4;
      valid_id    <= 1'b1;
    end
  end

  assign bus.IMemAddress   = pc;
  assign bus.PCOut         = pc;
  assign bus.InstructionID = instr_id;
  assign bus.PCPlus4ID     = pc_plus4_id;
  assign bus.ValidID       = valid_id;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  // Count IF/ID loads of valid words and of bubbles; stalled cycles count neither.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (bubble) begin
      bubble_count <= bubble_count + 32'd1;
    end else if (load) begin
      fetch_count  <= fetch_count + 32'd1;
    end
  end

  assign bus.FetchCount  = fetch_count;
  assign bus.BubbleCount = bubble_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The memory model returns
// (word index) * 3, i.e. IMemAddress[8:2]*3, so word addresses 0,4,8 read 0,3,6.
module tb_instruction_fetch_unit;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.IMemInstruction = {25'd0, bus.IMemAddress[8:2]} * 32'd3;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] iid,
                           input logic [31:0] p4, input logic v);
    chk({tag, ".pc"},    bus.IMemAddress,   pc);
    chk({tag, ".pcout"}, bus.PCOut,         pc);
    chk({tag, ".iid"},   bus.InstructionID, iid);
    chk({tag, ".p4"},    bus.PCPlus4ID,     p4);
    chk({tag, ".valid"}, {31'd0, bus.ValidID}, {31'd0, v});
  endtask

  task automatic clear_ctrl();
    bus.Stall = 0; bus.Flush = 0;
    bus.BranchTaken = 0; bus.BranchTarget = '0;
    bus.JumpReg = 0; bus.JumpRegTarget = '0;
    bus.Jump = 0; bus.JumpTarget = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_ctrl();
    Reset = 1;
    tick();
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    Reset = 0;

    // Free run
    tick(); chk_state("run1", 32'h4, 32'd0, 32'h4, 1'b1);
    tick(); chk_state("run2", 32'h8, 32'd3, 32'h8, 1'b1);

    // Stall three cycles at PC=8
    bus.Stall = 1;
    tick(); chk_state("stall1", 32'h8, 32'd3, 32'h8, 1'b1);
    tick(); chk_state("stall2", 32'h8, 32'd3, 32'h8, 1'b1);
    tick(); chk_state("stall3", 32'h8, 32'd3, 32'h8, 1'b1);
    bus.Stall = 0;
    tick(); chk_state("release", 32'hC, 32'd6, 32'hC, 1'b1);
    tick(); chk_state("run3", 32'h10, 32'd9, 32'h10, 1'b1);

    // Branch at PC=0x10
    bus.BranchTaken = 1; bus.BranchTarget = 32'h40;
    tick(); chk_state("br_bubble", 32'h40, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("br_target", 32'h44, 32'd48, 32'h44, 1'b1);

    // Jump to misaligned target
    bus.Jump = 1; bus.JumpTarget = 32'h23;
    tick(); chk_state("j_bubble", 32'h20, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("j_target", 32'h24, 32'd24, 32'h24, 1'b1);

    // Reset asserted mid-stall at PC=0x24
    bus.Stall = 1;
    tick(); chk_state("stall24", 32'h24, 32'd24, 32'h24, 1'b1);
    Reset = 1;
    tick(); chk_state("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    Reset = 0; bus.Stall = 0;
    tick(); chk_state("post_rst", 32'h4, 32'd0, 32'h4, 1'b1);

    // All redirects plus stall together
    bus.BranchTaken = 1; bus.BranchTarget = 32'h80;
    bus.JumpReg = 1; bus.JumpRegTarget = 32'h100;
    bus.Jump = 1; bus.JumpTarget = 32'h200;
    bus.Stall = 1;
    tick(); chk_state("prio_all", 32'h80, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("prio_tgt", 32'h84, 32'd96, 32'h84, 1'b1);

    // JumpReg beats Jump
    bus.JumpReg = 1; bus.JumpRegTarget = 32'h100;
    bus.Jump = 1; bus.JumpTarget = 32'h200;
    tick(); chk_state("prio_jr", 32'h100, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("jr_tgt", 32'h104, 32'd192, 32'h104, 1'b1);

    // Stall + Flush: PC holds, IF/ID bubbles
    bus.Stall = 1; bus.Flush = 1;
    tick(); chk_state("stall_flush", 32'h104, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("sf_resume", 32'h108, 32'd195, 32'h108, 1'b1);

    // Flush alone: PC advances, IF/ID bubbles
    bus.Flush = 1;
    tick(); chk_state("flush", 32'h10C, 32'h0, 32'h0, 1'b0);
    clear_ctrl();

    // PC wrap via jr to an unaligned top address
    bus.JumpReg = 1; bus.JumpRegTarget = 32'hFFFF_FFFF;
    tick(); chk_state("wrap_jr", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    clear_ctrl();
    tick(); chk_state("wrap", 32'h0, 32'd381, 32'h0, 1'b1);

`ifdef FETCH_PERF_EN
    Reset = 1;
    tick();
    chk("perf_rst_fetch",  bus.FetchCount,  32'd0);
    chk("perf_rst_bubble", bus.BubbleCount, 32'd0);
    Reset = 0;
    for (int unsigned i = 0; i < 5; i++) tick();
    bus.Flush = 1;
    tick();
    bus.Flush = 0; bus.Stall = 1;
    tick(); tick();
    bus.Stall = 0;
    chk("perf_fetch",  bus.FetchCount,  32'd5);
    chk("perf_bubble", bus.BubbleCount, 32'd1);
    Reset = 1;
    tick();
    chk("perf_clr_fetch",  bus.FetchCount,  32'd0);
    chk("perf_clr_bubble", bus.BubbleCount, 32'd0);
    Reset = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
